// File: rtl/pc_pkg.sv
// pc_pkg: shared widths and reset value for the program counter slice.
package pc_pkg;
  localparam int XLEN = 64;
  localparam int COND_W = 19;
  localparam int BR_W = 26;
  localparam logic [XLEN-1:0] PC_RESET = '0;
endpackage

// File: rtl/adder64_bit.sv
// adder64_bit: 64-bit full adder with signed overflow and carry-out.
module adder64_bit
  import pc_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            overflow,
  output logic            cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
  assign overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
endmodule

// File: rtl/program_counter.sv
// program_counter: 64-bit PC with sequential, PC-relative and register-indirect next-PC selection.
module program_counter
  import pc_pkg::*;
#(
  parameter int condAddrSize = COND_W,
  parameter int brAddrSize = BR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [condAddrSize-1:0] condAddr19,
  input  logic [brAddrSize-1:0]   brAddr26,
  input  logic                    uncondBr,
  input  logic                    branchReg,
  input  logic [XLEN-1:0]         Rd,
  input  logic                    branch,
  input  logic                    flagZero,
  input  logic                    flagNeg,
  input  logic                    opcode,
  output logic [XLEN-1:0]         currPC,
  output logic [XLEN-1:0]         pc_plus4
);
  logic [XLEN-1:0] pc_q, pc_d, offset, br_target, seq_pc;
  logic zero_taken, neg_taken, take_br;
  logic unused_ovf_seq, unused_cout_seq, unused_ovf_br, unused_cout_br;
  assign zero_taken = branch & flagZero & opcode;
  assign neg_taken = branch & flagNeg & ~opcode;
  assign take_br = uncondBr | zero_taken | neg_taken;
  // word offsets become byte offsets after sign extension
  assign offset = uncondBr
    ? {{(XLEN-brAddrSize-2){brAddr26[brAddrSize-1]}}, brAddr26, 2'b00}
    : {{(XLEN-condAddrSize-2){condAddr19[condAddrSize-1]}}, condAddr19, 2'b00};
  adder64_bit u_seq (
    .a(pc_q), .b(64'd4), .cin(1'b0),
    .sum(seq_pc), .overflow(unused_ovf_seq), .cout(unused_cout_seq)
  );
  adder64_bit u_br (
    .a(pc_q), .b(offset), .cin(1'b0),
    .sum(br_target), .overflow(unused_ovf_br), .cout(unused_cout_br)
  );
  assign pc_d = branchReg ? Rd : take_br ? br_target : seq_pc;
  always_ff @(posedge clk)
    if (!rst) pc_q <= PC_RESET;
    else pc_q <= pc_d;
  assign currPC = pc_q;
  assign pc_plus4 = seq_pc;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: scoreboard bench for program_counter, directed cases then random traffic.
module tb_program_counter;
  logic clk = 1'b0;
  logic rst;
  logic [18:0] cond;
  logic [25:0] br;
  logic uncond, breg, branch, fz, fn, op;
  logic [63:0] rd, curr, pp4, p;
  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  program_counter dut (
    .clk(clk), .rst(rst), .condAddr19(cond), .brAddr26(br),
    .uncondBr(uncond), .branchReg(breg), .Rd(rd), .branch(branch),
    .flagZero(fz), .flagNeg(fn), .opcode(op),
    .currPC(curr), .pc_plus4(pp4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [63:0] e);
    logic [63:0] x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check(tag, curr, x);
    check({tag, "_p4"}, pp4, x + 64'd4);
    p = x;
  endtask

  task automatic clr();
    cond = '0; br = '0; uncond = 0; breg = 0; rd = '0;
    branch = 0; fz = 0; fn = 0; op = 0;
  endtask

  function automatic logic [63:0] model();
    logic [63:0] off;
    if (!rst) return 64'd0;
    if (breg) return rd;
    off = uncond ? 64'(signed'(br)) : 64'(signed'(cond));
    if (uncond || (branch && fz && op) || (branch && fn && !op)) return p + off * 64'd4;
    return p + 64'd4;
  endfunction

  initial begin
    p = '0;
    clr();
    rst = 0;
    step("reset", 64'd0);
    rst = 1;
    for (int i = 0; i < 20; i++) step("seq", p + 64'd4);
    check("seq20", curr, 64'h50);
    check("seq20_p4", pp4, 64'd84);
    branch = 1; op = 1; fz = 1; cond = 19'd19;
    step("cbz_taken", p + 64'd76);
    fz = 0;
    step("cbz_not", p + 64'd4);
    op = 0; fn = 1; cond = 19'h7FFFF;
    step("blt_taken", p - 64'd4);
    op = 1; fz = 0;
    step("cbz_not2", p + 64'd4);
    clr();
    uncond = 1; br = 26'd50; cond = 19'd19;
    step("uncond", p + 64'd200);
    breg = 1; rd = 64'd12; branch = 1; fz = 1; op = 1;
    step("breg", 64'd12);
    rd = 64'hFFFF_FFFF_FFFF_FFFC;
    step("breg_top", 64'hFFFF_FFFF_FFFF_FFFC);
    clr();
    step("wrap", 64'd0);
    step("post_wrap", 64'd4);
    uncond = 1; br = 26'd50; breg = 1; rd = 64'h1234;
    rst = 0;
    step("rst_dominates", 64'd0);
    rst = 1; clr();
    br = 26'h3FFFFF0;
    uncond = 1;
    step("uncond_neg", p - 64'd64);
    for (int i = 0; i < 60; i++) begin
      cond = 19'($urandom); br = 26'($urandom);
      uncond = ($urandom_range(0, 3) == 0);
      breg = ($urandom_range(0, 5) == 0);
      rd = {$urandom, $urandom};
      branch = 1'($urandom); fz = 1'($urandom); fn = 1'($urandom); op = 1'($urandom);
      rst = ($urandom_range(0, 15) != 0);
      step("rand", model());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
